add_sub_seq: RTL and testbench
==============================

# add_sub_seq

Multi-precision add/subtract sequencer: accepts two WORDS×N-bit operands plus an add/subtract select over a valid/ready handshake. It processes them one N-bit slice per cycle, least-significant slice first, chaining the carry/borrow between slices, and presents the full-width result over an output valid/ready handshake. It lets wide arithmetic reuse a narrow N-bit adder/subtractor slice instead of a full-width adder.

## Interface
Parameters:
- N, 4, slice width in bits (≥2)
- WORDS, 4, number of slices; operand width W = N*WORDS (WORDS ≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  sequencer can accept; high only in IDLE and rst low
- a  input  W  operand A (unsigned or two's complement)
- b  input  W  operand B
- sub  input  1  0: A+B, 1: A−B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  W  A±B modulo 2^W
- co  output  1  final carry out (sub: 1 = no borrow, i.e. A ≥ B unsigned)
- ovf  output  1  signed two's-complement overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch a, b and sub
  - set idx=0 and carry=sub
  - go to RUN
- RUN, one slice per clock edge, slice k = idx:
  - bb = b[k] ^ {N{sub}}
  - {c, s} = a[k] + bb + carry, computed at N+1 bits
  - result[k] <= s; carry <= c; idx <= idx+1
  - On slice k = WORDS−1, also register co <= c and ovf <= (carry into slice MSB) ^ c. Then go to DONE.
- DONE: out_valid=1. On out_ready go to IDLE.
- Only one operation is in flight. No new request is accepted until the result handshake completes.
- in_valid with in_ready=0 is ignored and not queued. The requester holds in_valid.
- Latched operands are used for the whole operation. Changes on a, b or sub after acceptance have no effect.
- result, co and ovf are meaningful only while out_valid=1. They are held stable, unchanged, from out_valid rise until the handshake completes.
- result is not cleared between operations. Its slices are overwritten during RUN.
- idx width is clog2(WORDS) bits minimum, and it must not wrap before WORDS−1 is reached.

## Timing
- Reset values, asserted while rst=1 and on the first edge after:
  - state=IDLE, out_valid=0, in_ready=0 during rst
  - result=0, co=0, ovf=0, idx=0, carry=0
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from in_valid or out_ready to either output.
- Latency:
  - Request accepted at edge E0.
  - Slices processed at edges E1..E_WORDS.
  - out_valid is high from the cycle after edge E_WORDS, i.e. WORDS cycles after acceptance.
- Result handshake at edge Ed: out_valid=0 and in_ready=1 in the following cycle. A new request can be accepted at edge Ed+1.
- Minimum throughput: one operation per WORDS+2 cycles.
- Reset during RUN or DONE:
  - the operation is aborted with no out_valid pulse
  - outputs take their reset values
  - in_ready=1 in the first cycle with rst low
- rst has priority over any handshake on the same edge.
- Carry crosses slice boundaries only through the carry register. There is no full-width combinational carry chain.

## Test plan
All cases use N=4, WORDS=4, so W=16.
- Add 0x1234+0x0FCD, sub=0 → result=0x2201, co=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge, and in_ready=0 throughout.
- Full ripple: 0x7FFF+0x0001 gives result=0x8000, co=0, ovf=1. 0xFFFF+0x0001 gives result=0x0000, co=1, ovf=0.
- Subtract: 0x0003−0x0005 gives result=0xFFFE, co=0, ovf=0. 0x8000−0x0001 gives result=0x7FFF, co=1, ovf=1. 0x1234−0x1234 gives result=0x0000, co=1.
- Backpressure:
  - hold out_ready=0 for 6 cycles in DONE, with in_valid=1 and a, b toggling
  - result, co and ovf must stay constant and in_ready must stay 0
  - after out_ready=1 for one edge, in_ready=1 next cycle and the new request is accepted on the following edge
- Reset mid-operation:
  - assert rst for 1 cycle after 2 slices have been processed
  - out_valid must never assert for that operation
  - all outputs must be 0
  - in_ready=1 the cycle after rst falls, and a subsequent 0x0001+0x0001 yields 0x0002
- Random regression: 300 operations with random a, b and sub, plus random out_ready stalls. result, co and ovf must match a W+1-bit reference model, A + (B ^ {W{sub}}) + sub, for every completed handshake, and the count of completed handshakes must equal the count of accepted requests.

Source files
------------

// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-precision add/subtract sequencer.
// Accepts two W-bit operands (W = N*WORDS) and an add/subtract select over a
// valid/ready handshake. It processes one N-bit slice per clock, least
// significant first, and carries between slices only through a register.
// The full-width result is then presented over an output valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request
//   in_ready   request can be accepted (IDLE and rst low)
//   a, b       W-bit operands
//   sub        0: a+b, 1: a-b
//   out_valid  result available
//   out_ready  consumer accepts result
//   result     a +/- b modulo 2^W
//   co         final carry out (for sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
module add_sub_seq #(
    parameter int unsigned N     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] result,
    output logic               co,
    output logic               ovf
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [WORDS-1:0][N-1:0]  a_q;
    logic [WORDS-1:0][N-1:0]  b_q;
    logic [WORDS-1:0][N-1:0]  res_q;
    logic                     sub_q;
    logic                     carry;
    logic                     co_q;
    logic                     ovf_q;
    logic [IDX_W-1:0]         idx;

    logic [N-1:0]             a_sl;
    logic [N-1:0]             b_sl;
    logic [N:0]               sum;
    logic [N-1:0]             low_sum;
    logic                     cin_msb;

    // One N-bit slice adder; subtraction inverts B and uses carry-in = 1.
    // low_sum adds only the lower N-1 bits so its top bit is the carry into
    // the slice MSB, which the signed-overflow flag needs on the last slice.
    always_comb begin
        a_sl    = a_q[idx];
        b_sl    = b_q[idx] ^ {N{sub_q}};
        sum     = {1'b0, a_sl} + {1'b0, b_sl} + (N+1)'(carry);
        low_sum = {1'b0, a_sl[N-2:0]} + {1'b0, b_sl[N-2:0]} + N'(carry);
        cin_msb = low_sum[N-1];
    end

    // Sequencer: latch operands, walk the slices, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            res_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        idx   <= '0;
                        carry <= sub;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx] <= sum[N-1:0];
                    carry      <= sum[N];
                    idx        <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        co_q  <= sum[N];
                        ovf_q <= cin_msb ^ sum[N];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: self-checking bench for add_sub_seq (N=4, WORDS=4, W=16).
// Directed cases cover latency, ripple, subtract, backpressure and reset
// abort, followed by a randomized regression against an arithmetic model.
module tb_add_sub_seq;

    localparam int unsigned N     = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         co;
    logic         ovf;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_hs     = 0;

    add_sub_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: W+1-bit sum for result/co, signed integer range for ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms);
        logic [W:0] full;
        int         sa;
        int         sb;
        int         sr;
        logic       ov;
        full = {1'b0, ma} + {1'b0, mb ^ {W{ms}}} + (W+1)'(ms);
        sa   = int'($signed(ma));
        sb   = int'($signed(mb));
        sr   = ms ? (sa - sb) : (sa + sb);
        ov   = (sr > 32767) || (sr < -32768);
        return {ov, full};
    endfunction

    // Present a request and wait (bounded) for the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        bit ok;
        a        = ta;
        b        = tb;
        sub      = ts;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            n_acc++;
        end
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid with optional random stalls, compare, complete handshake.
    task automatic finish_op(input string tag, input logic [W-1:0] er, input logic ec,
                             input logic eo, input bit stall);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            out_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (out_valid && out_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            out_ready = 1'b0;
        end else begin
            check({tag, "_result"}, 32'(result), 32'(er));
            check({tag, "_co"}, 32'(co), 32'(ec));
            check({tag, "_ovf"}, 32'(ovf), 32'(eo));
            @(posedge clk);
            n_hs++;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W+1:0] exp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1 check("rst_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Basic add with exact latency
        send(16'h1234, 16'h0FCD, 1'b0);
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            check("lat_out_valid_low", 32'(out_valid), 32'd0);
            check("lat_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("lat_out_valid_high", 32'(out_valid), 32'd1);
        finish_op("add1", 16'h2201, 1'b0, 1'b0, 1'b0);

        // Full ripple and subtract cases
        send(16'h7FFF, 16'h0001, 1'b0);
        finish_op("ripple_7fff", 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        finish_op("ripple_ffff", 16'h0000, 1'b1, 1'b0, 1'b0);
        send(16'h0003, 16'h0005, 1'b1);
        finish_op("sub_3_5", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b1);
        finish_op("sub_8000_1", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(16'h1234, 16'h1234, 1'b1);
        finish_op("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold in DONE while a new request waits with toggling operands
        send(16'h7FFF, 16'h0001, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_reach_done", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            check("bp_result_hold", 32'(result), 32'h8000);
            check("bp_co_hold", 32'(co), 32'd0);
            check("bp_ovf_hold", 32'(ovf), 32'd1);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_high", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        n_hs++;
        @(negedge clk);
        out_ready = 1'b0;
        a   = 16'h0003;
        b   = 16'h0005;
        sub = 1'b1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        n_acc++;
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 32'(in_ready), 32'd0);
        finish_op("bp_next", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Reset after two slices have been processed
        send(16'hABCD, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_co", 32'(co), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        n_acc--; // aborted operation never produces a handshake
        #1 check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_out_valid", 32'(out_valid), 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0);
        finish_op("post_rst_add", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Random regression with output stalls
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (($urandom % 8) == 0) ra = 16'h8000;
            if (($urandom % 8) == 0) rb = 16'hFFFF;
            exp = model(ra, rb, rs);
            if (($urandom % 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(ra, rb, rs);
            finish_op("rand", exp[W-1:0], exp[W], exp[W+1], 1'b1);
        end

        check("handshakes_eq_accepts", 32'(n_hs), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
